// File: rtl/mem_sram_controller.sv
// MEM-stage load/store unit: each 32-bit access becomes two halfword accesses to a
// 16-bit SRAM, each lasting WAIT_CYCLES cycles, while freeze stalls the pipeline.
module mem_sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [3:0]         dest_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_Rm_in,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        alu_res_out,
  output logic [31:0]        mem_read_data,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0]  CNT_LAST   = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE       = 32'(BASE_ADDR);
  localparam bit          HOLD_CYCLE = (WAIT_CYCLES > 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] off;
  logic [30:0] lo_full;
  logic [30:0] hi_full;
  logic        mem_req;
  logic        last;
  logic        unused_bits;

  assign off         = alu_res_in - BASE;
  assign lo_full     = {off[31:2], 1'b0};
  assign hi_full     = {off[31:2], 1'b1};
  assign unused_bits = ^{off[1:0], lo_full, hi_full};
  assign mem_req     = mem_r_en_in | mem_w_en_in;
  assign last        = (cnt == CNT_LAST);

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign dest_out     = dest_in;
  assign alu_res_out  = alu_res_in;

  // DONE forces ready so the pipeline advances exactly once per completed word.
  assign ready  = (state == DONE) | ~mem_req;
  assign freeze = mem_req & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      mem_read_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (mem_w_en_in)      state <= WR_LO;
          else if (mem_r_en_in) state <= RD_LO;
        end
        RD_LO: begin
          if (last) begin
            cnt                 <= 4'd0;
            state               <= RD_HI;
            mem_read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (last) begin
            cnt                  <= 4'd0;
            state                <= DONE;
            mem_read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_LO: begin
          if (last) begin
            cnt   <= 4'd0;
            state <= WR_HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HI: begin
          if (last) begin
            cnt   <= 4'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pins decode straight from registered state so reset idles the bus immediately.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      RD_LO: sram_addr = lo_full[SRAM_AW-1:0];
      RD_HI: sram_addr = hi_full[SRAM_AW-1:0];
      WR_LO: begin
        sram_addr   = lo_full[SRAM_AW-1:0];
        sram_dq_out = val_Rm_in[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last & HOLD_CYCLE;
      end
      WR_HI: begin
        sram_addr   = hi_full[SRAM_AW-1:0];
        sram_dq_out = val_Rm_in[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last & HOLD_CYCLE;
      end
      default: ;
    endcase
  end

endmodule
